stopwatch_display_ctrl: RTL and testbench
=========================================

// Module: stopwatch_display_ctrl
// PURPOSE
//  Sequencing controller for the BCD counter / 7-seg display datapath. Runs a
//  NUM_DIGITS-digit cascaded decimal count from a prescaled clock tick under
//  start/stop/clear control. Time-multiplexes the digits onto one shared
//  bcd27seg decoder, one digit per scan slot.
//  Sits between the board push-button pulse logic and the display pins.
// PARAMETERS
//  TICK_DIV    100000  clk cycles per count increment (>=2)
//  SCAN_DIV    1000    clk cycles per display scan slot (>=1)
//  NUM_DIGITS  4       number of cascaded BCD digits / display positions (>=2)
// PORTS
//  clk         in   1              system clock, rising edge
//  reset       in   1              asynchronous, active-low reset
//  start_stop  in   1              1-cycle sync pulse: toggle run/pause
//  clear       in   1              1-cycle sync pulse: zero count, go idle
//  running     out  1              1 while in RUN
//  overflow    out  1              sticky: count wrapped past all-9s
//  bcd_value   out  4*NUM_DIGITS   full count, digit 0 = bits [3:0] (LSD)
//  scan_bcd    out  4              BCD of digit currently being scanned
//  digit_sel   out  NUM_DIGITS     one-hot active-high display enable
//  seg         out  7              {a,b,c,d,e,f,g} for scan_bcd, active-high
// BEHAVIOUR
//  - Reset (async, reset==0): state IDLE, all digits 0, prescaler 0, scan cnt 0,
//    scan idx 0; running=0, overflow=0, digit_sel=1 (digit 0), scan_bcd=0,
//    seg=7'b1111110. All registers update on posedge clk only otherwise.
//  - FSM states IDLE, RUN, PAUSE (registered):
//    IDLE -start_stop-> RUN; RUN -start_stop-> PAUSE; PAUSE -start_stop-> RUN.
//    clear in any state -> IDLE; clear has priority over same-cycle start_stop.
//  - running is registered: start_stop at edge k -> running=1 after edge k.
//  - Prescaler: counts 0..TICK_DIV-1 only in RUN; tick asserted internally when
//    prescaler==TICK_DIV-1 in RUN; prescaler then wraps to 0. First increment
//    lands TICK_DIV edges after entering RUN from IDLE.
//  - PAUSE freezes prescaler and digits (partial interval resumes on RUN).
//  - clear zeroes digits, prescaler, overflow in the same edge; scan unaffected.
//  - Digit cascade is synchronous: digit i increments on tick when all lower
//    digits ==9; a digit at 9 that increments goes to 0. All updates in the
//    same edge (no ripple clocks; carry is combinational enable).
//  - All digits ==9 at tick: every digit -> 0, overflow<=1 (sticky), stays RUN.
//  - Digits never hold values 10..15; if seen, scan decode shows 7'b0000001.
//  - Scan: free-running in all states. scan cnt 0..SCAN_DIV-1; at terminal,
//    idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1. digit_sel = 1<<idx (registered);
//    scan_bcd = digit[idx] combinational from registered idx/digits; seg is
//    bcd27seg(scan_bcd), zero added latency. digit_sel always exactly one-hot.
//  - Reset asserted mid-count or mid-scan: immediate return to reset values.
// STRUCTURE
//  - Package stopwatch_pkg: state_t enum {IDLE,RUN,PAUSE}, SEG_BLANK_ERR=7'b0000001,
//    BCD_MAX=4'd9.
//  - Sub-module bcd_digit_sync: one synchronous mod-10 digit (clk, reset, en,
//    clr -> q[3:0], at_max); generate NUM_DIGITS instances, en_i = tick & AND(at_max[<i]).
//  - One bcd27seg instance for seg output.
// TESTING (TICK_DIV=4, SCAN_DIV=2, NUM_DIGITS=4)
//  - Reset then start_stop pulse -> running=1 next edge; bcd_value=16'h0001
//    exactly 4 edges later, 16'h0002 after 8.
//  - Preload via run to 16'h0009, one tick -> 16'h0010; from 16'h0999 -> 16'h1000.
//  - Run to 16'h9999, one tick -> 16'h0000, overflow=1, running=1; clear ->
//    overflow=0, bcd_value=0, running=0 next edge.
//  - RUN 2 edges into interval, start_stop (PAUSE) 20 edges -> value unchanged;
//    start_stop -> increment after 2 more edges (prescaler held).
//  - Same-cycle clear+start_stop in RUN -> IDLE, running=0, count 0.
//  - With bcd_value=16'h4321: digit_sel 0001,0010,0100,1000,0001 every 2 edges;
//    scan_bcd 1,2,3,4; seg 0110000,1101101,1111001,0110011. Async reset mid-scan ->
//    digit_sel=0001 immediately.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counter / display controller.
package stopwatch_pkg;

   // Run-control states of the stopwatch.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   // Segment pattern shown for an illegal BCD code (only the g segment lit).
   localparam logic [6:0] SEG_BLANK_ERR = 7'b0000001;

   // Largest legal value of a decimal digit.
   localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd27seg.sv
// BCD to seven-segment decoder, output order {a,b,c,d,e,f,g}, active-high.
module bcd27seg
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Glyph lookup; codes 10..15 never occur in a healthy counter and are flagged.
   always_comb begin
      seg = SEG_BLANK_ERR;
      case (bcd)
         4'd0:    seg = 7'b1111110;
         4'd1:    seg = 7'b0110000;
         4'd2:    seg = 7'b1101101;
         4'd3:    seg = 7'b1111001;
         4'd4:    seg = 7'b0110011;
         4'd5:    seg = 7'b1011011;
         4'd6:    seg = 7'b1011111;
         4'd7:    seg = 7'b1110000;
         4'd8:    seg = 7'b1111111;
         4'd9:    seg = 7'b1111011;
         default: seg = SEG_BLANK_ERR;
      endcase
   end

endmodule

// File: rtl/bcd_digit_sync.sv
// One synchronous mod-10 digit. The enable is the combinational carry from the
// lower digits, so every digit of the chain updates on the same clock edge.
module bcd_digit_sync
   import stopwatch_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       clr,
   output logic [3:0] q,
   output logic       at_max
);

   logic [3:0] q_reg;

   // Digit register: clear wins over increment, and 9 rolls over to 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_reg <= 4'd0;
      end else if (clr) begin
         q_reg <= 4'd0;
      end else if (en) begin
         q_reg <= (q_reg >= BCD_MAX) ? 4'd0 : q_reg + 4'd1;
      end
   end

   assign q      = q_reg;
   assign at_max = (q_reg == BCD_MAX);

endmodule

// File: rtl/stopwatch_display_ctrl.sv
// Stopwatch sequencing controller: run/pause/clear FSM, tick prescaler,
// cascaded decimal digits and a free-running multiplexed display scan.
module stopwatch_display_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV   = 100000,
   parameter int SCAN_DIV   = 1000,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start_stop,
   input  logic                    clear,
   output logic                    running,
   output logic                    overflow,
   output logic [4*NUM_DIGITS-1:0] bcd_value,
   output logic [3:0]              scan_bcd,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [6:0]              seg
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   state_t                state_reg, state_next;
   logic                  running_reg;
   logic [PW-1:0]         pre_reg;
   logic                  overflow_reg;
   logic                  tick;
   logic [NUM_DIGITS-1:0] at_max;
   logic [NUM_DIGITS-1:0] digit_en;
   logic [3:0]            digit_q [NUM_DIGITS];
   logic [SW-1:0]         scan_cnt_reg;
   logic [IW-1:0]         scan_idx_reg;
   logic [NUM_DIGITS-1:0] digit_sel_reg;

   // Next run-control state; clear overrides a same-cycle start_stop.
   always_comb begin
      state_next = state_reg;
      if (clear) begin
         state_next = IDLE;
      end else if (start_stop) begin
         case (state_reg)
            IDLE:    state_next = RUN;
            RUN:     state_next = PAUSE;
            PAUSE:   state_next = RUN;
            default: state_next = IDLE;
         endcase
      end
   end

   // State register with a matching registered running flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         running_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         running_reg <= (state_next == RUN);
      end
   end

   assign tick = (state_reg == RUN) && (pre_reg == PRE_LAST);

   // Prescaler only advances in RUN, so a paused partial interval resumes intact.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_reg <= '0;
      end else if (clear) begin
         pre_reg <= '0;
      end else if (state_reg == RUN) begin
         pre_reg <= tick ? '0 : pre_reg + 1'b1;
      end
   end

   // Sticky flag set when a tick rolls the whole count over from all nines.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_reg <= 1'b0;
      end else if (clear) begin
         overflow_reg <= 1'b0;
      end else if (tick && (&at_max)) begin
         overflow_reg <= 1'b1;
      end
   end

   // Digit chain: each digit is enabled when the tick fires and all lower digits are 9.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         if (gi == 0) begin : g_lsd
            assign digit_en[gi] = tick;
         end else begin : g_upper
            assign digit_en[gi] = tick & (&at_max[gi-1:0]);
         end

         bcd_digit_sync u_digit (
            .clk    (clk),
            .reset  (reset),
            .en     (digit_en[gi]),
            .clr    (clear),
            .q      (digit_q[gi]),
            .at_max (at_max[gi])
         );

         assign bcd_value[4*gi +: 4] = digit_q[gi];
      end
   endgenerate

   // Free-running scan: slot counter, digit index and one-hot enable advance together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_cnt_reg  <= '0;
         scan_idx_reg  <= '0;
         digit_sel_reg <= NUM_DIGITS'(1);
      end else if (scan_cnt_reg == SCAN_LAST) begin
         scan_cnt_reg  <= '0;
         scan_idx_reg  <= (scan_idx_reg == IDX_LAST) ? '0 : scan_idx_reg + 1'b1;
         digit_sel_reg <= {digit_sel_reg[NUM_DIGITS-2:0], digit_sel_reg[NUM_DIGITS-1]};
      end else begin
         scan_cnt_reg  <= scan_cnt_reg + 1'b1;
      end
   end

   assign scan_bcd  = digit_q[scan_idx_reg];
   assign digit_sel = digit_sel_reg;
   assign running   = running_reg;
   assign overflow  = overflow_reg;

   bcd27seg u_seg (
      .bcd (scan_bcd),
      .seg (seg)
   );

endmodule

// File: tb/tb_stopwatch_display_ctrl.sv
// Randomized self-checking bench for stopwatch_display_ctrl against an
// integer-count reference model of the stopwatch and the display scan.
module tb_stopwatch_display_ctrl;

   localparam int TICK_DIV   = 4;
   localparam int SCAN_DIV   = 2;
   localparam int NUM_DIGITS = 4;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_stop = 1'b0;
   logic        clear = 1'b0;
   logic        running;
   logic        overflow;
   logic [15:0] bcd_value;
   logic [3:0]  scan_bcd;
   logic [3:0]  digit_sel;
   logic [6:0]  seg;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: plain integer count, edges spent in the current interval,
   // and edges since reset for the scan position.
   int m_state = M_IDLE;
   int m_count = 0;
   int m_elapsed = 0;
   int m_ovf = 0;
   int m_scan_edges = 0;

   logic [6:0] glyph [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
   logic [3:0] exp_scan_bcd [0:3] = '{4'd1, 4'd2, 4'd3, 4'd4};
   logic [6:0] exp_scan_seg [0:3] = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011};

   stopwatch_display_ctrl #(
      .TICK_DIV   (TICK_DIV),
      .SCAN_DIV   (SCAN_DIV),
      .NUM_DIGITS (NUM_DIGITS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start_stop (start_stop),
      .clear      (clear),
      .running    (running),
      .overflow   (overflow),
      .bcd_value  (bcd_value),
      .scan_bcd   (scan_bcd),
      .digit_sel  (digit_sel),
      .seg        (seg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r = '0;
      for (int d = 0; d < 4; d++) r[4*d +: 4] = 4'((v / (10 ** d)) % 10);
      return r;
   endfunction

   function automatic int scan_pos();
      return (m_scan_edges / SCAN_DIV) % NUM_DIGITS;
   endfunction

   task automatic model_reset();
      m_state = M_IDLE;
      m_count = 0;
      m_elapsed = 0;
      m_ovf = 0;
      m_scan_edges = 0;
   endtask

   task automatic model_edge(input logic ss, input logic clr);
      m_scan_edges++;
      if (clr) begin
         m_state = M_IDLE;
         m_count = 0;
         m_elapsed = 0;
         m_ovf = 0;
      end else begin
         if (m_state == M_RUN) begin
            m_elapsed++;
            if (m_elapsed == TICK_DIV) begin
               m_elapsed = 0;
               if (m_count == 9999) m_ovf = 1;
               m_count = (m_count + 1) % 10000;
            end
         end
         if (ss) m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
      end
   endtask

   task automatic check_all();
      int p;
      int dig;
      p = scan_pos();
      dig = (m_count / (10 ** p)) % 10;
      check("running", 32'(running), 32'(m_state == M_RUN));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("bcd_value", 32'(bcd_value), 32'(to_bcd(m_count)));
      check("digit_sel", 32'(digit_sel), 32'(1 << p));
      check("scan_bcd", 32'(scan_bcd), 32'(dig));
      check("seg", 32'(seg), 32'(glyph[dig]));
   endtask

   // One clock cycle: drive inputs, clock edge, update model, check at negedge.
   task automatic step(input logic ss, input logic clr);
      start_stop = ss;
      clear = clr;
      @(posedge clk);
      model_edge(ss, clr);
      #1;
      start_stop = 1'b0;
      clear = 1'b0;
      @(negedge clk);
      check_all();
   endtask

   task automatic run_until(input int target, input int budget);
      int n;
      n = 0;
      while (m_count != target && n < budget) begin
         step(1'b0, 1'b0);
         n++;
      end
      check("run_until_reached", 32'(m_count == target), 32'd1);
      $display("run to %0d after %0d cycles: bcd_value=%h overflow=%0b", target, n, bcd_value, overflow);
   endtask

   initial begin
      logic ss;
      logic clr;

      // Reset values.
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_running", 32'(running), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_bcd_value", 32'(bcd_value), 32'd0);
      check("rst_digit_sel", 32'(digit_sel), 32'b0001);
      check("rst_scan_bcd", 32'(scan_bcd), 32'd0);
      check("rst_seg", 32'(seg), 32'b1111110);
      $display("reset: running=%0b digit_sel=%b seg=%b", running, digit_sel, seg);
      reset = 1'b1;
      model_reset();

      // Start: running next edge, first increment 4 edges later, second after 8.
      step(1'b1, 1'b0);
      check("start_running", 32'(running), 32'd1);
      repeat (3) step(1'b0, 1'b0);
      check("pre_first_tick", 32'(bcd_value), 32'h0000);
      step(1'b0, 1'b0);
      check("first_tick", 32'(bcd_value), 32'h0001);
      repeat (4) step(1'b0, 1'b0);
      check("second_tick", 32'(bcd_value), 32'h0002);
      $display("start: bcd_value=%h running=%0b", bcd_value, running);

      // Carry boundaries and full wrap.
      run_until(10, 100);
      check("carry_0010", 32'(bcd_value), 32'h0010);
      run_until(1000, 5000);
      check("carry_1000", 32'(bcd_value), 32'h1000);
      run_until(9999, 40000);
      check("pre_wrap_ovf", 32'(overflow), 32'd0);
      run_until(0, 10);
      check("wrap_value", 32'(bcd_value), 32'h0000);
      check("wrap_ovf", 32'(overflow), 32'd1);
      check("wrap_running", 32'(running), 32'd1);
      step(1'b0, 1'b1);
      check("clr_ovf", 32'(overflow), 32'd0);
      check("clr_value", 32'(bcd_value), 32'd0);
      check("clr_running", 32'(running), 32'd0);
      $display("clear after wrap: overflow=%0b running=%0b", overflow, running);

      // Pause mid-interval holds the prescaler.
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check("pause_running", 32'(running), 32'd0);
      repeat (20) step(1'b0, 1'b0);
      check("pause_hold", 32'(bcd_value), 32'h0000);
      step(1'b1, 1'b0);
      check("resume_running", 32'(running), 32'd1);
      step(1'b0, 1'b0);
      check("resume_plus1", 32'(bcd_value), 32'h0000);
      step(1'b0, 1'b0);
      check("resume_plus2", 32'(bcd_value), 32'h0001);
      $display("pause/resume: bcd_value=%h", bcd_value);

      // Clear beats same-cycle start_stop while running.
      step(1'b1, 1'b1);
      check("clr_ss_running", 32'(running), 32'd0);
      check("clr_ss_value", 32'(bcd_value), 32'd0);
      $display("clear+start_stop: running=%0b bcd_value=%h", running, bcd_value);

      // Randomized control pulses.
      for (int i = 0; i < 600; i++) begin
         ss = ($urandom_range(0, 7) == 0);
         clr = ($urandom_range(0, 39) == 0);
         step(ss, clr);
         if (ss || clr)
            $display("rand cycle %0d: start_stop=%0b clear=%0b -> running=%0b bcd_value=%h", i, ss, clr, running, bcd_value);
      end

      // Scan pattern with a held count of 4321.
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      run_until(4321, 20000);
      step(1'b1, 1'b0);
      check("scan_hold_value", 32'(bcd_value), 32'h4321);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0);
         check("scan_digit", 32'(scan_bcd), 32'(exp_scan_bcd[scan_pos()]));
         check("scan_glyph", 32'(seg), 32'(exp_scan_seg[scan_pos()]));
      end
      $display("scan 4321: digit_sel=%b scan_bcd=%0d seg=%b", digit_sel, scan_bcd, seg);

      // Asynchronous reset in the middle of a scan slot.
      while (scan_pos() == 0) step(1'b0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check("areset_digit_sel", 32'(digit_sel), 32'b0001);
      check("areset_value", 32'(bcd_value), 32'd0);
      check("areset_running", 32'(running), 32'd0);
      check("areset_seg", 32'(seg), 32'b1111110);
      $display("async reset: digit_sel=%b bcd_value=%h", digit_sel, bcd_value);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      repeat (8) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
